// File: rtl/voice_mixer.sv
// Sums N_VOICES signed voices one per clock, applies master gain, saturates; out_valid rises N_VOICES+2 cycles after the tick.
// Output held while out_valid && !out_ready; ticks arriving while busy are dropped and flagged as overrun.
module voice_mixer #(
    parameter int N_VOICES   = 8,
    parameter int WIDTH      = 24,
    parameter int VOL_WIDTH  = 8,
    parameter int GAIN_SHIFT = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sample_tick,
    input  logic [N_VOICES-1:0][WIDTH-1:0]   voices,
    input  logic [N_VOICES-1:0]              voice_enable,
    input  logic [VOL_WIDTH-1:0]             master_volume,
    input  logic                             clear_flags,
    output logic signed [WIDTH-1:0]          out_sample,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             clip,
    output logic                             overrun
);

    localparam int ACC_W  = WIDTH + $clog2(N_VOICES) + 1;
    localparam int PROD_W = ACC_W + VOL_WIDTH + 1;
    localparam int IDX_W  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACCUM, SCALE, SAT, OUTPUT} state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [N_VOICES-1:0][WIDTH-1:0]  snap_voices;
    logic [N_VOICES-1:0]             snap_en;
    logic [VOL_WIDTH-1:0]            snap_vol;
    logic signed [ACC_W-1:0]         acc;
    logic [IDX_W-1:0]                idx;
    logic signed [PROD_W-1:0]        scaled;

    logic                            last_voice;
    logic                            tick_busy;
    logic signed [ACC_W-1:0]         voice_term;
    logic signed [PROD_W-1:0]        product;
    logic                            sat_hi;
    logic                            sat_lo;
    logic signed [WIDTH-1:0]         sat_val;

    assign last_voice = (idx == IDX_W'(N_VOICES - 1));
    assign tick_busy  = sample_tick && (state != IDLE);
    assign voice_term = snap_en[idx] ? ACC_W'($signed(snap_voices[idx])) : '0;

    // Zero-extended volume keeps the gain positive; the accumulator width guarantees no truncation here.
    assign product = PROD_W'(acc) * PROD_W'($signed({1'b0, snap_vol}));

    assign sat_hi  = (scaled > SAT_MAX);
    assign sat_lo  = (scaled < SAT_MIN);
    assign sat_val = sat_hi ? SAT_MAX[WIDTH-1:0] : (sat_lo ? SAT_MIN[WIDTH-1:0] : scaled[WIDTH-1:0]);

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUTPUT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_tick) state_nxt = ACCUM;
            ACCUM:   if (last_voice)  state_nxt = SCALE;
            SCALE:   state_nxt = SAT;
            SAT:     state_nxt = OUTPUT;
            OUTPUT:  if (out_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_voices <= '0;
            snap_en     <= '0;
            snap_vol    <= '0;
            acc         <= '0;
            idx         <= '0;
            scaled      <= '0;
            out_sample  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        snap_voices <= voices;
                        snap_en     <= voice_enable;
                        snap_vol    <= master_volume;
                        acc         <= '0;
                        idx         <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + voice_term;
                    idx <= last_voice ? '0 : idx + 1'b1;
                end
                SCALE:   scaled     <= product >>> GAIN_SHIFT;
                SAT:     out_sample <= sat_val;
                default: ;
            endcase
        end
    end

    // A set condition on the same edge as clear_flags takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if ((state == SAT) && (sat_hi || sat_lo)) begin
                clip <= 1'b1;
            end else if (clear_flags) begin
                clip <= 1'b0;
            end
            if (tick_busy) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
